phy_rx_lane_align: RTL

//   Receive end of the 2-lane serial PHY link. Recovers half-word boundaries on each

---
 rtl/phy_rx_lane_align_pkg.sv | 14 +
 rtl/phy_rx_lane_align_sync.sv | 75 +++++++
 rtl/phy_rx_lane_align.sv | 101 ++++++++++
 3 files changed

// File: rtl/phy_rx_lane_align_pkg.sv
// Shared constants and lane FSM state type for the 2-lane PHY receive path.
// The transmitter uses the same idle pattern.
package phy_rx_lane_align_pkg;

  localparam logic [15:0] DEF_IDLE_PAT   = 16'hBC7C;
  localparam int unsigned DEF_LOCK_COUNT = 4;

  typedef enum logic [1:0] {
    LANE_SEARCH = 2'd0,
    LANE_CHECK  = 2'd1,
    LANE_LOCKED = 2'd2
  } lane_state_e;

endpackage

// File: rtl/phy_rx_lane_align_sync.sv
// Single-lane half-word boundary recovery: shift register, bit counter and
// SEARCH/CHECK/LOCKED alignment FSM. Emits each half-word once locked.
module phy_rx_lane_sync
  import phy_rx_lane_align_pkg::*;
#(
  parameter logic [15:0] IDLE_PAT   = DEF_IDLE_PAT,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        serial_in,
  output logic [15:0] hw,
  output logic        hw_strobe,
  output logic        locked
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

  lane_state_e   state_q, state_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [MW-1:0] matches_q, matches_d;
  logic          boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LANE_SEARCH;
      shreg_q   <= '0;
      cnt_q     <= '0;
      matches_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      matches_q <= matches_d;
    end
  end

  // The counter is zeroed on the matching cycle, so it reads 15 exactly
  // 16 cycles later, when shreg holds the next complete half-word.
  always_comb begin
    shreg_d   = {shreg_q[14:0], serial_in};
    cnt_d     = cnt_q + 4'd1;
    state_d   = state_q;
    matches_d = matches_q;
    hw_strobe = 1'b0;
    boundary  = (cnt_q == 4'd15);
    case (state_q)
      LANE_SEARCH: begin
        if (shreg_q == IDLE_PAT) begin
          state_d   = (LOCK_COUNT <= 1) ? LANE_LOCKED : LANE_CHECK;
          matches_d = MW'(1);
          cnt_d     = '0;
        end
      end
      LANE_CHECK: begin
        if (boundary) begin
          if (shreg_q == IDLE_PAT) begin
            matches_d = matches_q + 1'b1;
            if (32'(matches_q) + 32'd1 >= LOCK_COUNT) state_d = LANE_LOCKED;
          end else begin
            state_d   = LANE_SEARCH;
            matches_d = '0;
          end
        end
      end
      LANE_LOCKED: hw_strobe = boundary;
      default:     state_d   = LANE_SEARCH;
    endcase
  end

  assign hw     = shreg_q;
  assign locked = (state_q == LANE_LOCKED);

endmodule

// File: rtl/phy_rx_lane_align.sv
// 2-lane PHY receiver top: per-lane alignment, skew-tolerant pairing of the
// two half-words and the registered parallel word output.
module phy_rx_lane_align
  import phy_rx_lane_align_pkg::*;
#(
  parameter logic [15:0] IDLE_PAT   = DEF_IDLE_PAT,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        bus_serial_0,
  input  logic        bus_serial_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active
);

  logic [15:0] hw0, hw1;
  logic        strobe0, strobe1, locked0, locked1;

  logic [15:0] hw0_q, hw0_d, hw1_q, hw1_d;
  logic        fresh0_q, fresh0_d, fresh1_q, fresh1_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;

  logic [15:0] hw0_eff, hw1_eff;
  logic        fresh0_eff, fresh1_eff;

  phy_rx_lane_sync #(.IDLE_PAT(IDLE_PAT), .LOCK_COUNT(LOCK_COUNT)) u_lane0 (
    .clk       (clk_32f),
    .rst_n     (reset),
    .serial_in (bus_serial_0),
    .hw        (hw0),
    .hw_strobe (strobe0),
    .locked    (locked0)
  );

  phy_rx_lane_sync #(.IDLE_PAT(IDLE_PAT), .LOCK_COUNT(LOCK_COUNT)) u_lane1 (
    .clk       (clk_32f),
    .rst_n     (reset),
    .serial_in (bus_serial_1),
    .hw        (hw1),
    .hw_strobe (strobe1),
    .locked    (locked1)
  );

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      hw0_q    <= '0;
      hw1_q    <= '0;
      fresh0_q <= 1'b0;
      fresh1_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      hw0_q    <= hw0_d;
      hw1_q    <= hw1_d;
      fresh0_q <= fresh0_d;
      fresh1_q <= fresh1_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end
  end

  // A strobe in the current cycle is folded in combinationally so the word
  // is registered one cycle after the later lane's boundary.
  always_comb begin
    fresh0_eff = fresh0_q | strobe0;
    fresh1_eff = fresh1_q | strobe1;
    hw0_eff    = strobe0 ? hw0 : hw0_q;
    hw1_eff    = strobe1 ? hw1 : hw1_q;
    hw0_d      = hw0_eff;
    hw1_d      = hw1_eff;
    fresh0_d   = fresh0_eff;
    fresh1_d   = fresh1_eff;
    data_d     = data_q;
    valid_d    = 1'b0;
    active_d   = locked0 & locked1;
    if (!active_q) begin
      hw0_d    = hw0_q;
      hw1_d    = hw1_q;
      fresh0_d = 1'b0;
      fresh1_d = 1'b0;
    end else if (fresh0_eff && fresh1_eff) begin
      fresh0_d = 1'b0;
      fresh1_d = 1'b0;
      if (!(hw0_eff == IDLE_PAT && hw1_eff == IDLE_PAT)) begin
        valid_d = 1'b1;
        data_d  = {hw0_eff, hw1_eff};
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule
